uart_tx_fifo: RTL and testbench

Parametrised UART transmitter with an input FIFO, programmable baud divider, per-frame parity and stop-bit options, and a ready/overflow handshake. It succeeds the fixed 8-bit, one-bit-per-clock, single-frame transmitter. The host can queue up to FIFO_DEPTH frames, and they are sent back-to-back with no idle gap. It sits between the host write path and the serial `tx` pin.

---
 rtl/uart_tx_fifo.sv | 231 +++++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter fed by a small frame FIFO.
// Each queued entry carries its own payload and framing options.
// Frames go out back-to-back, LSB first, with an optional parity bit and one or two stop bits.
module uart_tx_fifo #(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned CLKS_PER_BIT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              tx_start,
  input  logic              parity_en,
  input  logic              even_parity,
  input  logic              two_stop,
  output logic              tx,
  output logic              busy,
  output logic              full,
  output logic              empty,
  output logic              frame_done,
  output logic              overflow
);

  localparam int unsigned ENTRY_W = DATA_W + 3;
  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned BAUD_W  = $clog2(CLKS_PER_BIT + 1);
  localparam int unsigned IDX_W   = $clog2(DATA_W + 1);

  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // FIFO storage and bookkeeping
  logic [ENTRY_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               r_overflow;

  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  logic [ENTRY_W-1:0] w_entry;
  logic [DATA_W-1:0]  w_e_data;
  logic               w_e_pen;
  logic               w_e_par;
  logic               w_e_two;

  // Transmitter state
  state_t             r_state,    w_state_nxt;
  logic [DATA_W-1:0]  r_shift,    w_shift_nxt;
  logic               r_par_en,   w_par_en_nxt;
  logic               r_par_bit,  w_par_bit_nxt;
  logic               r_two_stop, w_two_stop_nxt;
  logic [BAUD_W-1:0]  r_baud,     w_baud_nxt;
  logic [IDX_W-1:0]   r_idx,      w_idx_nxt;
  logic               r_stop_cnt, w_stop_cnt_nxt;
  logic               r_tx,       w_tx_nxt;
  logic               r_frame_done, w_frame_done_nxt;
  logic               w_bit_end;
  logic               w_load;

  assign w_full   = (r_count == CNT_FULL);
  assign w_empty  = (r_count == '0);
  assign w_push   = tx_start && !w_full;
  assign w_entry  = r_mem[r_rd_ptr];
  assign w_e_data = w_entry[ENTRY_W-1:3];
  assign w_e_pen  = w_entry[2];
  assign w_e_par  = w_entry[1] ? (^w_e_data) : (~^w_e_data);
  assign w_e_two  = w_entry[0];

  // Capture payload and framing options at write time
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {data_in, parity_en, even_parity, two_stop};
    end
  end

  // FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (tx_start && w_full) r_overflow <= 1'b1;
    end
  end

  // Transmitter state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_shift      <= '0;
      r_par_en     <= 1'b0;
      r_par_bit    <= 1'b0;
      r_two_stop   <= 1'b0;
      r_baud       <= '0;
      r_idx        <= '0;
      r_stop_cnt   <= 1'b0;
      r_tx         <= 1'b1;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_shift      <= w_shift_nxt;
      r_par_en     <= w_par_en_nxt;
      r_par_bit    <= w_par_bit_nxt;
      r_two_stop   <= w_two_stop_nxt;
      r_baud       <= w_baud_nxt;
      r_idx        <= w_idx_nxt;
      r_stop_cnt   <= w_stop_cnt_nxt;
      r_tx         <= w_tx_nxt;
      r_frame_done <= w_frame_done_nxt;
    end
  end

  assign w_bit_end = (r_baud == BAUD_LAST);

  // Next-state and serial line decode; a frame load is shared by IDLE and the end of STOP
  always_comb begin
    w_state_nxt      = r_state;
    w_shift_nxt      = r_shift;
    w_par_en_nxt     = r_par_en;
    w_par_bit_nxt    = r_par_bit;
    w_two_stop_nxt   = r_two_stop;
    w_baud_nxt       = w_bit_end ? '0 : r_baud + 1'b1;
    w_idx_nxt        = r_idx;
    w_stop_cnt_nxt   = r_stop_cnt;
    w_tx_nxt         = r_tx;
    w_frame_done_nxt = 1'b0;
    w_load           = 1'b0;
    w_pop            = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_tx_nxt   = 1'b1;
        w_baud_nxt = '0;
        w_load     = !w_empty;
      end
      S_START: begin
        if (w_bit_end) begin
          w_state_nxt = S_DATA;
          w_tx_nxt    = r_shift[0];
          w_shift_nxt = r_shift >> 1;
          w_idx_nxt   = '0;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          if (r_idx == IDX_LAST) begin
            if (r_par_en) begin
              w_state_nxt = S_PARITY;
              w_tx_nxt    = r_par_bit;
            end else begin
              w_state_nxt    = S_STOP;
              w_tx_nxt       = 1'b1;
              w_stop_cnt_nxt = 1'b0;
            end
          end else begin
            w_tx_nxt    = r_shift[0];
            w_shift_nxt = r_shift >> 1;
            w_idx_nxt   = r_idx + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (w_bit_end) begin
          w_state_nxt    = S_STOP;
          w_tx_nxt       = 1'b1;
          w_stop_cnt_nxt = 1'b0;
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          if (r_stop_cnt == r_two_stop) begin
            w_frame_done_nxt = 1'b1;
            if (!w_empty) begin
              w_load = 1'b1;
            end else begin
              w_state_nxt = S_IDLE;
              w_tx_nxt    = 1'b1;
            end
          end else begin
            w_stop_cnt_nxt = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_tx_nxt    = 1'b1;
      end
    endcase

    if (w_load) begin
      w_pop          = 1'b1;
      w_state_nxt    = S_START;
      w_shift_nxt    = w_e_data;
      w_par_en_nxt   = w_e_pen;
      w_par_bit_nxt  = w_e_par;
      w_two_stop_nxt = w_e_two;
      w_baud_nxt     = '0;
      w_tx_nxt       = 1'b0;
    end
  end

  assign tx         = r_tx;
  assign busy       = (r_state != S_IDLE);
  assign full       = w_full;
  assign empty      = w_empty;
  assign frame_done = r_frame_done;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo: two instances (fast/deep and slow/shallow),
// checked every cycle against a serial-stream reference model plus directed checks.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       sel;
  logic       tx_start;
  logic       parity_en;
  logic       even_parity;
  logic       two_stop;
  logic [7:0] data_in;

  logic a_start, b_start;
  logic a_tx, a_busy, a_full, a_empty, a_fd, a_ovf;
  logic b_tx, b_busy, b_full, b_empty, b_fd, b_ovf;
  logic obs_tx, obs_busy, obs_full, obs_empty, obs_fd, obs_ovf;

  always #5 clk = ~clk;

  assign a_start   = tx_start & ~sel;
  assign b_start   = tx_start & sel;
  assign obs_tx    = sel ? b_tx    : a_tx;
  assign obs_busy  = sel ? b_busy  : a_busy;
  assign obs_full  = sel ? b_full  : a_full;
  assign obs_empty = sel ? b_empty : a_empty;
  assign obs_fd    = sel ? b_fd    : a_fd;
  assign obs_ovf   = sel ? b_ovf   : a_ovf;

  uart_tx_fifo #(.DATA_W(8), .FIFO_DEPTH(4), .CLKS_PER_BIT(1)) u_a (
    .clk(clk), .rst(rst), .data_in(data_in), .tx_start(a_start),
    .parity_en(parity_en), .even_parity(even_parity), .two_stop(two_stop),
    .tx(a_tx), .busy(a_busy), .full(a_full), .empty(a_empty),
    .frame_done(a_fd), .overflow(a_ovf)
  );

  uart_tx_fifo #(.DATA_W(8), .FIFO_DEPTH(2), .CLKS_PER_BIT(4)) u_b (
    .clk(clk), .rst(rst), .data_in(data_in), .tx_start(b_start),
    .parity_en(parity_en), .even_parity(even_parity), .two_stop(two_stop),
    .tx(b_tx), .busy(b_busy), .full(b_full), .empty(b_empty),
    .frame_done(b_fd), .overflow(b_ovf)
  );

  int passes = 0;
  int total  = 0;

  // Reference model: queued frames and the remaining serial stream (one entry per clock)
  int          cpb;
  int          depth;
  logic [10:0] fq[$];
  bit          line[$];
  bit          m_fd;
  bit          m_ovf;

  // Directed-observation scratch
  bit hist[$];
  int fd_cnt;
  int busy_cnt;
  int low_cnt;
  bit full_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic load_frame(input logic [10:0] e);
    bit         b[$];
    logic [7:0] d;
    d = e[7:0];
    b.push_back(1'b0);
    for (int i = 0; i < 8; i++) b.push_back(d[i]);
    if (e[8]) b.push_back(e[9] ? (^d) : (~^d));
    b.push_back(1'b1);
    if (e[10]) b.push_back(1'b1);
    foreach (b[i]) begin
      for (int k = 0; k < cpb; k++) line.push_back(b[i]);
    end
  endtask

  task automatic model_edge();
    int c0;
    int n;
    c0 = fq.size();
    n  = line.size();
    if (rst) begin
      fq.delete();
      line.delete();
      m_fd  = 1'b0;
      m_ovf = 1'b0;
    end else begin
      m_fd = (n == 1);
      if (n > 0) void'(line.pop_front());
      if (line.size() == 0 && c0 > 0) load_frame(fq.pop_front());
      if (tx_start) begin
        if (c0 == depth) m_ovf = 1'b1;
        else fq.push_back({two_stop, even_parity, parity_en, data_in});
      end
    end
  endtask

  task automatic check_all();
    chk("tx",         obs_tx,    (line.size() != 0) ? line[0] : 1'b1);
    chk("busy",       obs_busy,  line.size() != 0);
    chk("full",       obs_full,  fq.size() == depth);
    chk("empty",      obs_empty, fq.size() == 0);
    chk("frame_done", obs_fd,    m_fd);
    chk("overflow",   obs_ovf,   m_ovf);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_all();
      hist.push_back(obs_tx);
      fd_cnt    += obs_fd;
      busy_cnt  += obs_busy;
      low_cnt   += (obs_tx == 1'b0);
      full_seen |= obs_full;
    end
  endtask

  task automatic clr();
    hist.delete();
    fd_cnt    = 0;
    busy_cnt  = 0;
    low_cnt   = 0;
    full_seen = 1'b0;
  endtask

  task automatic select(input bit s);
    sel   = s;
    cpb   = s ? 4 : 1;
    depth = s ? 2 : 4;
    rst   = 1'b1;
    run(2);
    rst   = 1'b0;
  endtask

  initial begin
    logic [9:0] got;
    logic [7:0] dec;

    rst = 1'b1; sel = 1'b0; tx_start = 1'b0; parity_en = 1'b0;
    even_parity = 1'b0; two_stop = 1'b0; data_in = '0;
    cpb = 1; depth = 4; m_fd = 1'b0; m_ovf = 1'b0;
    clr();

    // Reset state
    select(1'b0);
    chk("rst_tx", obs_tx, 1);
    chk("rst_busy", obs_busy, 0);
    chk("rst_empty", obs_empty, 1);
    chk("rst_full", obs_full, 0);
    chk("rst_ovf", obs_ovf, 0);

    // 0xA5, no parity, one stop
    clr();
    data_in = 8'hA5; tx_start = 1'b1; run(1);
    tx_start = 1'b0; run(12);
    for (int i = 0; i < 10; i++) got[i] = hist[i+1];
    chk("a5_bits", got, 10'b1101001010);
    chk("a5_done", fd_cnt, 1);
    chk("a5_busy", busy_cnt, 10);

    // 0x07 with parity, even then odd
    for (int p = 1; p >= 0; p--) begin
      clr();
      data_in = 8'h07; parity_en = 1'b1; even_parity = p[0]; tx_start = 1'b1; run(1);
      tx_start = 1'b0; run(14);
      chk("par_bit", hist[10], p[0]);
      chk("par_stop", hist[11], 1);
      chk("par_busy", busy_cnt, 11);
      chk("par_done", fd_cnt, 1);
    end
    parity_en = 1'b0;

    // Overflow: six consecutive writes into a 4-deep FIFO
    select(1'b0);
    clr();
    for (int v = 1; v <= 6; v++) begin
      data_in = 8'(v); tx_start = 1'b1; run(1);
    end
    tx_start = 1'b0; run(55);
    for (int j = 0; j < 5; j++) begin
      for (int i = 0; i < 8; i++) dec[i] = hist[2 + 10*j + i];
      chk("ovf_frame", dec, j + 1);
    end
    chk("ovf_done", fd_cnt, 5);
    chk("ovf_busy", busy_cnt, 50);
    chk("ovf_full_seen", full_seen, 1);
    chk("ovf_sticky", obs_ovf, 1);

    // Reset during data bit 3 of 0x3C with two frames queued
    select(1'b0);
    data_in = 8'h3C; tx_start = 1'b1; run(1);
    data_in = 8'h11; run(1);
    data_in = 8'h22; run(1);
    tx_start = 1'b0; run(3);
    chk("mid_bit3", obs_tx, 1);
    chk("mid_busy", obs_busy, 1);
    rst = 1'b1; run(1); rst = 1'b0;
    chk("mid_tx", obs_tx, 1);
    chk("mid_busy0", obs_busy, 0);
    chk("mid_empty", obs_empty, 1);
    clr();
    run(20);
    chk("mid_nodone", fd_cnt, 0);
    chk("mid_nolow", low_cnt, 0);

    // Configuration captured at write time while a frame is in flight
    clr();
    data_in = 8'hA5; parity_en = 1'b0; tx_start = 1'b1; run(1);
    data_in = 8'h07; parity_en = 1'b1; even_parity = 1'b1; run(1);
    tx_start = 1'b0; even_parity = 1'b0; data_in = 8'hFF; run(30);
    chk("cap_par", hist[20], 1);
    chk("cap_stop", hist[21], 1);
    chk("cap_done", fd_cnt, 2);
    chk("cap_busy", busy_cnt, 21);
    parity_en = 1'b0;

    // Slow instance: 4 clocks per bit, two stop bits, all-zero payload
    select(1'b1);
    clr();
    data_in = 8'h00; two_stop = 1'b1; tx_start = 1'b1; run(1);
    tx_start = 1'b0; two_stop = 1'b0; run(50);
    chk("slow_low", low_cnt, 36);
    chk("slow_busy", busy_cnt, 44);
    chk("slow_done", fd_cnt, 1);
    chk("slow_edge", {hist[36], hist[37]}, 2'b01);

    // Randomised traffic on both instances
    for (int s = 0; s < 2; s++) begin
      select(s[0]);
      for (int c = 0; c < 400; c++) begin
        tx_start    = ($urandom_range(0, 99) < 30);
        data_in     = 8'($urandom);
        parity_en   = 1'($urandom);
        even_parity = 1'($urandom);
        two_stop    = 1'($urandom);
        rst         = ($urandom_range(0, 299) == 0);
        run(1);
      end
      tx_start = 1'b0;
      rst      = 1'b0;
      run(120);
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
